projectile_engine: RTL

Parametrised projectile motion engine for the artillery game; successor to the single-cannon flight logic. On a launch request it reads sine/cosine of the firing angle from a quarter-wave ROM and converts angle and power into signed velocities. It then integrates position once per game tick, applying gravity and wind, until a collision, a board-edge exit or a flight timeout. It sits between the player-control FSM, which supplies launch parameters, and the collision/render logic, which consumes position and returns a collide flag.

---
 rtl/projectile_pkg.sv | 25 ++
 rtl/projectile_engine_if.sv | 33 +++
 rtl/trig_rom.sv | 34 +++
 rtl/projectile_engine.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/projectile_pkg.sv
// Shared types and constants for the projectile engine and its trig ROM.
package projectile_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_SIN,
        S_RD_COS,
        S_CALC,
        S_FLY,
        S_DONE
    } state_e;

    localparam logic [1:0] RES_NONE    = 2'b00;
    localparam logic [1:0] RES_HIT     = 2'b01;
    localparam logic [1:0] RES_OUT     = 2'b10;
    localparam logic [1:0] RES_TIMEOUT = 2'b11;

    // One ROM entry per angle code; the cosine is read from the mirrored address.
    function automatic int rom_depth(input int angle_w);
        return 1 << angle_w;
    endfunction

    localparam int ROM_DEPTH = rom_depth(8);

endpackage

// File: rtl/projectile_engine_if.sv
// Launch/tick/collide inputs and position/status outputs of the projectile engine.
interface projectile_engine_if #(
    parameter int POS_W   = 18,
    parameter int ANGLE_W = 8,
    parameter int POWER_W = 8,
    parameter int WIND_W  = 8
);
    logic               tick;
    logic               launch;
    logic [POS_W-1:0]   start_pos_x;
    logic [POS_W-1:0]   start_pos_y;
    logic               direction;
    logic [ANGLE_W-1:0] angle;
    logic [POWER_W-1:0] power;
    logic [WIND_W-1:0]  wind;
    logic               collide;
    logic               ready;
    logic               flying;
    logic [POS_W-1:0]   pos_x;
    logic [POS_W-1:0]   pos_y;
    logic               done;
    logic [1:0]         result;

    modport master (
        output tick, launch, start_pos_x, start_pos_y, direction, angle, power, wind, collide,
        input  ready, flying, pos_x, pos_y, done, result
    );

    modport slave (
        input  tick, launch, start_pos_x, start_pos_y, direction, angle, power, wind, collide,
        output ready, flying, pos_x, pos_y, done, result
    );
endinterface

// File: rtl/trig_rom.sv
// Quarter-wave sine ROM: entry a = round((2^TRIG_W-1) * sin(a * 90deg / (2^ANGLE_W-1))), 1-cycle read.
module trig_rom
    import projectile_pkg::*;
#(
    parameter int ANGLE_W = 8,
    parameter int TRIG_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ANGLE_W-1:0] addr,
    output logic [TRIG_W-1:0]  data_q
);
    localparam int DEPTH = rom_depth(ANGLE_W);

    function automatic logic [TRIG_W-1:0] rom_entry(input int a);
        real rad;
        rad = real'(a) * 3.141592653589793 / (2.0 * real'(DEPTH - 1));
        return TRIG_W'($rtoi(real'((1 << TRIG_W) - 1) * $sin(rad) + 0.5));
    endfunction

    logic [TRIG_W-1:0] lut [DEPTH];
    logic [TRIG_W-1:0] data_d;

    for (genvar a = 0; a < DEPTH; a++) begin : g_lut
        assign lut[a] = rom_entry(a);
    end

    always_comb data_d = lut[addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= '0;
        else        data_q <= data_d;
    end
endmodule

// File: rtl/projectile_engine.sv
// Projectile flight engine: trig lookup at launch, then per-tick position integration
// with gravity, wind, collision, board-exit clamping and flight timeout.
module projectile_engine
    import projectile_pkg::*;
#(
    parameter int POS_W     = 18,
    parameter int ANGLE_W   = 8,
    parameter int POWER_W   = 8,
    parameter int TRIG_W    = 8,
    parameter int VEL_W     = 20,
    parameter int WIND_W    = 8,
    parameter int BOARD_X   = 200000,
    parameter int BOARD_Y   = 150000,
    parameter int GRAVITY   = 256,
    parameter int MAX_TICKS = 4095
) (
    input  logic                clock_50m,
    input  logic                rst_n,
    projectile_engine_if.slave  bus
);
    localparam int PROD_W = POWER_W + TRIG_W;
    // Wide enough that position + saturated velocity can never wrap.
    localparam int SUM_W  = ((POS_W > VEL_W) ? POS_W : VEL_W) + 2;
    localparam int CNT_W  = $clog2(MAX_TICKS + 1);
    localparam logic signed [VEL_W-1:0] VEL_MAX = {1'b0, {(VEL_W-1){1'b1}}};
    localparam logic signed [VEL_W-1:0] VEL_MIN = {1'b1, {(VEL_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] LIM_X   = SUM_W'(BOARD_X);
    localparam logic signed [SUM_W-1:0] LIM_Y   = SUM_W'(BOARD_Y);

    state_e                     state_q, state_d;
    logic [POS_W-1:0]           sx_q, sx_d, sy_q, sy_d, pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic                       dir_q, dir_d;
    logic [ANGLE_W-1:0]         angle_q, angle_d, rom_addr;
    logic [POWER_W-1:0]         power_q, power_d;
    logic [TRIG_W-1:0]          sin_q, sin_d, rom_data;
    logic signed [VEL_W-1:0]    vx_q, vx_d, vy_q, vy_d, mag_x, mag_y, wind_ext;
    logic [CNT_W-1:0]           cnt_q, cnt_d, cnt_inc;
    logic [1:0]                 result_q, result_d;
    logic                       ready_q, ready_d, flying_q, flying_d, done_q, done_d;
    logic signed [SUM_W-1:0]    nx, ny;
    logic                       x_out, y_out;

    function automatic logic signed [VEL_W-1:0] sat_add(input logic signed [VEL_W-1:0] a,
                                                        input logic signed [VEL_W-1:0] b);
        logic [VEL_W:0] s;
        s = {a[VEL_W-1], a} + {b[VEL_W-1], b};
        if (s[VEL_W] != s[VEL_W-1]) return s[VEL_W] ? VEL_MIN : VEL_MAX;
        return s[VEL_W-1:0];
    endfunction

    function automatic logic [POS_W-1:0] clamp(input logic signed [SUM_W-1:0] v,
                                               input logic signed [SUM_W-1:0] lim);
        if (v[SUM_W-1]) return '0;
        if (v > lim)    return lim[POS_W-1:0];
        return v[POS_W-1:0];
    endfunction

    trig_rom #(.ANGLE_W(ANGLE_W), .TRIG_W(TRIG_W)) u_rom (
        .clk    (clock_50m),
        .rst_n  (rst_n),
        .addr   (rom_addr),
        .data_q (rom_data)
    );

    // Products are unsigned magnitudes; direction/up sign is applied in CALC.
    assign mag_x    = VEL_W'(PROD_W'(power_q) * PROD_W'(rom_data));
    assign mag_y    = VEL_W'(PROD_W'(power_q) * PROD_W'(sin_q));
    assign wind_ext = VEL_W'(signed'(bus.wind));
    assign nx       = SUM_W'(signed'({1'b0, pos_x_q})) + SUM_W'(vx_q);
    assign ny       = SUM_W'(signed'({1'b0, pos_y_q})) + SUM_W'(vy_q);
    assign x_out    = nx[SUM_W-1] || (nx > LIM_X);
    assign y_out    = ny[SUM_W-1] || (ny > LIM_Y);
    assign cnt_inc  = cnt_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        dir_d    = dir_q;
        angle_d  = angle_q;
        power_d  = power_q;
        sin_d    = sin_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        cnt_d    = cnt_q;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        result_d = result_q;
        rom_addr = angle_q;
        case (state_q)
            S_IDLE: if (bus.launch) begin
                sx_d    = bus.start_pos_x;
                sy_d    = bus.start_pos_y;
                dir_d   = bus.direction;
                angle_d = bus.angle;
                power_d = bus.power;
                state_d = S_RD_SIN;
            end
            S_RD_SIN: state_d = S_RD_COS;
            S_RD_COS: begin
                sin_d    = rom_data;
                rom_addr = ~angle_q;
                state_d  = S_CALC;
            end
            S_CALC: begin
                vx_d     = dir_q ? mag_x : -mag_x;
                vy_d     = -mag_y;
                pos_x_d  = sx_q;
                pos_y_d  = sy_q;
                cnt_d    = '0;
                result_d = RES_NONE;
                state_d  = S_FLY;
            end
            S_FLY: if (bus.tick) begin
                if (bus.collide) begin
                    result_d = RES_HIT;
                    state_d  = S_DONE;
                end else if (x_out || y_out) begin
                    pos_x_d  = clamp(nx, LIM_X);
                    pos_y_d  = clamp(ny, LIM_Y);
                    result_d = RES_OUT;
                    state_d  = S_DONE;
                end else begin
                    pos_x_d = nx[POS_W-1:0];
                    pos_y_d = ny[POS_W-1:0];
                    vx_d    = sat_add(vx_q, wind_ext);
                    vy_d    = sat_add(vy_q, VEL_W'(GRAVITY));
                    cnt_d   = cnt_inc;
                    if (cnt_inc == CNT_W'(MAX_TICKS)) begin
                        result_d = RES_TIMEOUT;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ready_d  = (state_d == S_IDLE);
        flying_d = (state_d == S_FLY);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clock_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sx_q     <= '0;
            sy_q     <= '0;
            dir_q    <= 1'b0;
            angle_q  <= '0;
            power_q  <= '0;
            sin_q    <= '0;
            vx_q     <= '0;
            vy_q     <= '0;
            cnt_q    <= '0;
            pos_x_q  <= '0;
            pos_y_q  <= '0;
            result_q <= RES_NONE;
            ready_q  <= 1'b1;
            flying_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            dir_q    <= dir_d;
            angle_q  <= angle_d;
            power_q  <= power_d;
            sin_q    <= sin_d;
            vx_q     <= vx_d;
            vy_q     <= vy_d;
            cnt_q    <= cnt_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            flying_q <= flying_d;
            done_q   <= done_d;
        end
    end

    assign bus.ready  = ready_q;
    assign bus.flying = flying_q;
    assign bus.done   = done_q;
    assign bus.pos_x  = pos_x_q;
    assign bus.pos_y  = pos_y_q;
    assign bus.result = result_q;
endmodule
